// File: rtl/tx_msg_scroller.sv
// Scrolls each accepted UART byte across six active-low 7-segment digits.
// Optional macro TX_MSG_SCROLLER_DP_EN: HEXTM0 dp lights while overflow is set.
module tx_msg_scroller #(
  parameter int SCROLL_DIV = 25000000,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] HEXTM0,
  output logic [7:0] HEXTM1,
  output logic [7:0] HEXTM2,
  output logic [7:0] HEXTM3,
  output logic [7:0] HEXTM4,
  output logic [7:0] HEXTM5
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCROLL_DIV - 1);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       win [6];
  logic             ovf;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             tick;

  function automatic logic [7:0] enc(input logic [7:0] c);
    logic [7:0] s;
    case (c)
      8'h30:        s = 8'hC0;
      8'h31:        s = 8'hF9;
      8'h32:        s = 8'hA4;
      8'h33:        s = 8'hB0;
      8'h34:        s = 8'h99;
      8'h35:        s = 8'h92;
      8'h36:        s = 8'h82;
      8'h37:        s = 8'hF8;
      8'h38:        s = 8'h80;
      8'h39:        s = 8'h90;
      8'h41, 8'h61: s = 8'h88;
      8'h42, 8'h62: s = 8'h83;
      8'h43, 8'h63: s = 8'hC6;
      8'h44, 8'h64: s = 8'hA1;
      8'h45, 8'h65: s = 8'h86;
      8'h46, 8'h66: s = 8'h8E;
      8'h20:        s = 8'hFF;
      default:      s = 8'hBF;
    endcase
    return s;
  endfunction

  assign full       = (count == FULLC);
  assign empty      = (count == '0);
  assign char_ready = !full && !clr;
  assign push       = char_valid && char_ready;
  assign tick       = !empty && (cnt == LAST);
  // clr discards a tick landing on the same edge
  assign pop        = tick && !clr;
  assign busy       = !empty;
  assign overflow   = ovf;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= char_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (char_valid && full) ovf <= 1'b1;
      if (empty || tick) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) win[i] <= 8'hFF;
    end else if (clr) begin
      for (int i = 0; i < 6; i++) win[i] <= 8'hFF;
    end else if (pop) begin
      for (int i = 5; i > 0; i--) win[i] <= win[i-1];
      win[0] <= enc(mem[rptr]);
    end
  end

`ifdef TX_MSG_SCROLLER_DP_EN
  assign HEXTM0 = {~ovf, win[0][6:0]};
`else
  assign HEXTM0 = win[0];
`endif
  assign HEXTM1 = win[1];
  assign HEXTM2 = win[2];
  assign HEXTM3 = win[3];
  assign HEXTM4 = win[4];
  assign HEXTM5 = win[5];

endmodule

// File: tb/tb_tx_msg_scroller.sv
// Scoreboard bench for tx_msg_scroller: predicted codes queued with
// their due cycle, compared when that edge has passed.
module tb_tx_msg_scroller;

  localparam int SD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       busy;
  logic       overflow;
  logic [7:0] h0, h1, h2, h3, h4, h5;
  logic [47:0] win;

  typedef struct {
    logic [7:0] code;
    int         due;
  } ent_t;

  ent_t        q[$];
  ent_t        m_e;
  logic [47:0] m_x;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_due = 0;
  logic [47:0] exp_w = '1;
  logic        ov_m = 1'b0;

  tx_msg_scroller #(
    .SCROLL_DIV(SD),
    .DEPTH(8),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .busy(busy),
    .overflow(overflow),
    .HEXTM0(h0),
    .HEXTM1(h1),
    .HEXTM2(h2),
    .HEXTM3(h3),
    .HEXTM4(h4),
    .HEXTM5(h5)
  );

  assign win = {h5, h4, h3, h2, h1, h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc_m(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      case (c - 8'h30)
        8'd0: return 8'hC0;
        8'd1: return 8'hF9;
        8'd2: return 8'hA4;
        8'd3: return 8'hB0;
        8'd4: return 8'h99;
        8'd5: return 8'h92;
        8'd6: return 8'h82;
        8'd7: return 8'hF8;
        8'd8: return 8'h80;
        default: return 8'h90;
      endcase
    end
    case (c | 8'h20)
      8'h61: return 8'h88;
      8'h62: return 8'h83;
      8'h63: return 8'hC6;
      8'h64: return 8'hA1;
      8'h65: return 8'h86;
      8'h66: return 8'h8E;
      default: ;
    endcase
    if (c == 8'h20) return 8'hFF;
    return 8'hBF;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].due == cyc) begin
        m_e = q.pop_front();
        exp_w = {exp_w[39:0], m_e.code};
        m_x = exp_w;
`ifdef TX_MSG_SCROLLER_DP_EN
        m_x[7] = ~ov_m;
`endif
        chk("hex0", {40'h0, h0}, {40'h0, m_x[7:0]});
        chk("window", win, m_x);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit acc);
    int due;
    char_valid = 1'b1;
    char_data  = b;
    if (acc) begin
      due = ((cyc + 1) > last_due ? cyc + 1 : last_due) + SD;
      last_due = due;
      q.push_back('{enc_m(b), due});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    char_valid = 1'b0;
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 48'(q.size()), 48'h0);
  endtask

  task automatic do_clr(input bit vld);
    clr        = 1'b1;
    char_valid = vld;
    char_data  = 8'h31;
    q.delete();
    exp_w    = '1;
    ov_m     = 1'b0;
    last_due = 0;
    @(negedge clk);
    clr        = 1'b0;
    char_valid = 1'b0;
    chk("clr_win", win, '1);
    chk("clr_busy", {47'h0, busy}, 48'h0);
    chk("clr_ovf", {47'h0, overflow}, 48'h0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #4;
    chk("rst_win", win, '1);
    chk("rst_busy", {47'h0, busy}, 48'h0);
    chk("rst_ovf", {47'h0, overflow}, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {47'h0, char_ready}, 48'h1);

    send(8'h35, 1'b1);
    chk("one_busy", {47'h0, busy}, 48'h1);
    chk("one_wait", win, '1);
    drain();
    chk("one_idle", {47'h0, busy}, 48'h0);
    chk("one_win", win, 48'hFFFF_FFFF_FF92);

    do_clr(1'b0);
    send(8'h30, 1'b1);
    send(8'h41, 1'b1);
    send(8'h37, 1'b1);
    send(8'h2D, 1'b1);
    drain();
    chk("seq_win", win, 48'hFFFF_C088_F8BF);

    for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b1);
    chk("full_ready", {47'h0, char_ready}, 48'h0);
    ov_m = 1'b1;
    send(8'h39, 1'b0);
    chk("full_ovf", {47'h0, overflow}, 48'h1);
`ifdef TX_MSG_SCROLLER_DP_EN
    chk("full_dp", {47'h0, h0[7]}, 48'h0);
`endif
    drain();
    idle(SD + 2);
    chk("full_idle", {47'h0, busy}, 48'h0);

    do_clr(1'b0);
    send(8'h32, 1'b1);
    send(8'h33, 1'b1);
    send(8'h34, 1'b1);
    idle(20);
    do_clr(1'b1);
    idle(3 * SD);
    chk("clr_after_busy", {47'h0, busy}, 48'h0);
    chk("clr_after_win", win, '1);

    send(8'h7A, 1'b1);
    send(8'h66, 1'b1);
    send(8'h20, 1'b1);
    drain();
    chk("zfs_win", win, 48'hFFFF_FFBF_8EFF);

    send(8'h35, 1'b1);
    idle(5);
    #3 rst_n = 1'b0;
    q.delete();
    exp_w    = '1;
    ov_m     = 1'b0;
    last_due = 0;
    #1;
    chk("arst_win", win, '1);
    chk("arst_busy", {47'h0, busy}, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3 * SD);
    chk("arst_after_win", win, '1);
    chk("arst_after_busy", {47'h0, busy}, 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_msg_scroller.md
Name: tx_msg_scroller

Overview:
- Upstream producer of the HEXTM0..HEXTM5 display set consumed by the TX-mode 7-segment multiplexer.
- Takes each byte accepted for UART transmission and scrolls it right-to-left across six 7-segment digits at a fixed rate.
- A small FIFO decouples byte arrival from the scroll rate.
- Outputs are registered, active-low segment codes.

Parameters:
- SCROLL_DIV, 25000000: clock cycles per scroll step (0.5 s at 50 MHz); must be >= 2.
- DEPTH, 8: FIFO entries; power of 2, >= 2.
- CNT_W, 25: scroll counter width; 2^CNT_W must be >= SCROLL_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of window, FIFO, counter and flag
- char_valid  in  1  byte offered on char_data
- char_data  in  8  ASCII byte being transmitted
- char_ready  out  1  FIFO can accept; transfer occurs when char_valid && char_ready
- busy  out  1  FIFO non-empty
- overflow  out  1  sticky: byte offered while FIFO full
- HEXTM0..HEXTM5  out  8 each  segment codes {dp,g,f,e,d,c,b,a}, active-low; HEXTM0 rightmost/newest, HEXTM5 leftmost/oldest

Behaviour:
- Reset (async, rst_n=0): all HEXTM* = 8'hFF (blank); FIFO empty; cnt=0; busy=0; overflow=0; char_ready=1 after release.
- char_ready = !full && !clr (combinational). busy = (count != 0), registered-state based.
- Push: char_valid && char_ready on an edge writes char_data at the write pointer. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Full push attempt (char_valid && full, no clr): byte dropped; overflow set; FIFO unchanged.
- Scroll counter:
  - cnt increments each cycle while count != 0.
  - cnt forced to 0 while count == 0.
  - tick = (cnt == SCROLL_DIV-1) && count != 0; cnt wraps to 0 on tick.
- On tick: pop head byte; HEXTM5<=HEXTM4, HEXTM4<=HEXTM3, ..., HEXTM1<=HEXTM0, HEXTM0<=enc(popped byte).
- Latency: a byte pushed into an empty FIFO at edge E appears on HEXTM0 at edge E+SCROLL_DIV. Subsequent queued bytes appear every SCROLL_DIV cycles.
- Simultaneous push and pop: both take effect; count unchanged. Push while full and pop in the same cycle is still refused (char_ready=0).
- Window never clears on its own; the last six characters stay displayed when idle.
- enc() (dp bit always 1):
  - Digits: '0'=C0, '1'=F9, '2'=A4, '3'=B0, '4'=99, '5'=92, '6'=82, '7'=F8, '8'=80, '9'=90.
  - Letters, either case: A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - Space (8'h20) = FF.
  - All other bytes = BF ('-').
- clr (sync, highest priority):
  - At the edge: window = FF, FIFO flushed, cnt = 0, overflow = 0.
  - Any push offered that cycle is not accepted (char_ready=0).
  - A tick due that cycle is discarded.
- Reset mid-scroll: immediate return to reset values. No partial shift is visible.

Optional Feature:
- Macro TX_MSG_SCROLLER_DP_EN.
- Defined: bit 7 (dp) of HEXTM0 = ~overflow, so the rightmost decimal point lights while overflow is set. All other digits keep dp=1.
- Undefined: every dp bit is constant 1. The overflow port behaves identically in both builds.

Test Plan:
- Reset, SCROLL_DIV=4: hold rst_n=0 -> all HEXTM*=FF, busy=0, char_ready=1, overflow=0.
- Push '5' at edge E into empty FIFO -> busy=1 after E; HEXTM0=92 from edge E+4, HEXTM1..5=FF; busy=0 after E+4.
- Back-to-back push "0A7-" (4 bytes), SCROLL_DIV=4 -> HEXTM0 shows C0, 88, F8, BF at edges E+4, +8, +12, +16; final window HEXTM3..0 = C0,88,F8,BF, HEXTM5..4 = FF.
- DEPTH=8: push 9 bytes with no pop possible (SCROLL_DIV large) -> char_ready=0 after the 8th push; 9th byte dropped; overflow=1. With TX_MSG_SCROLLER_DP_EN defined: HEXTM0[7]=0.
- Assert clr for one cycle mid-scroll with 3 bytes queued and char_valid=1 -> next cycle all HEXTM*=FF, busy=0, overflow=0, offered byte not stored.
- Push 'z', 'f', ' ' -> HEXTM0 codes BF, 8E, FF in order. Assert rst_n=0 between steps -> outputs FF immediately, asynchronously, without a clock edge.
